prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Hardware instruction-memory loader. Receives a program image as a byte stream
//  over a valid/ready interface and writes it word by word into the CPU
//  instruction memory. Holds the CPU in reset until the image is loaded and its
//  checksum passes, then releases the core to fetch from word 0.
//  The hardware writer for insMem; the synthesizable replacement for simulation preload.
// PARAMETERS
//  IM_DEPTH  1024  instruction memory depth in 32-bit words
//  ADDR_W    10    width of im_addr; must satisfy 2**ADDR_W >= IM_DEPTH
// PORTS
//  clk           in   1       system clock; all logic on posedge
//  rst           in   1       asynchronous, active-high reset
//  in_valid      in   1       byte on in_data is valid
//  in_data       in   8       stream byte
//  in_ready      out  1       loader accepts a byte; handshake = in_valid & in_ready
//  reload        in   1       1-cycle pulse; restarts the load from DONE or ERR
//  im_we         out  1       instruction memory write enable (1-cycle pulse)
//  im_addr       out  ADDR_W  instruction memory word index
//  im_wdata      out  32      instruction word to write
//  cpu_rst       out  1       reset to CPU; high except in DONE
//  done          out  1       image loaded and checksum OK
//  err           out  1       load failed (oversize count or bad checksum)
//  words_loaded  out  16      number of words written so far
// BEHAVIOUR
//  Frame: CNT_HI, CNT_LO (16-bit word count N, big-endian), then 4*N payload bytes
//   (each word big-endian, MSB first), then one CSUM byte = XOR of all payload bytes.
//   Header bytes are not included in the checksum.
//  Reset values: state=CNT_HI, in_ready=1, im_we=0, im_addr=0, im_wdata=0,
//   cpu_rst=1, done=0, err=0, words_loaded=0, checksum acc=0.
//  States: CNT_HI -> CNT_LO -> (N==0 ? CSUM : DATA) -> CSUM -> DONE | ERR.
//   CNT_LO: if N > IM_DEPTH -> ERR on the cycle after the CNT_LO handshake.
//   DATA: shift bytes into a 32-bit assembly reg; byte-in-word counter 0..3.
//    On the handshake of byte 3: im_wdata <= assembled word, im_addr <= words_loaded,
//    im_we <= 1 for exactly the next cycle; words_loaded increments with im_we.
//    After word N-1 is written, go to CSUM.
//   CSUM: compare byte with acc; equal -> DONE, else -> ERR.
//  in_ready = 1 in CNT_HI, CNT_LO, DATA, CSUM; 0 in DONE and ERR. No stalls:
//   write is registered, so back-to-back bytes at 1 byte/cycle are accepted.
//  in_valid gaps of any length leave all state unchanged; in_data ignored when no handshake.
//  cpu_rst = 0 only in DONE (registered; deasserts the cycle DONE is entered).
//  done = (state==DONE), err = (state==ERR); mutually exclusive.
//  reload in DONE/ERR: next state CNT_HI, cpu_rst=1, done=err=0, words_loaded=0,
//   acc=0. reload in any other state is ignored.
//  Async rst mid-load: immediate return to reset values; partial words already
//   written stay in memory; no im_we is generated for a partial word.
//  words_loaded saturates at IM_DEPTH (guaranteed by CNT_LO check); im_addr never
//   exceeds IM_DEPTH-1.
// TESTING
//  1 Frame 00 03 | 20 02 00 05 | 20 03 00 0C | 00 00 00 00 | 08 at 1 byte/cycle ->
//    im_we at addr 0,1,2 with 0x20020005, 0x2003000C, 0x00000000; done=1, cpu_rst falls.
//  2 Same frame with CSUM 0x09 -> 3 writes, then err=1, done=0, cpu_rst stays 1, in_ready=0.
//  3 Count 0x0401 (1025 > IM_DEPTH) -> err=1 after CNT_LO, zero im_we pulses.
//  4 Count 0x0000 then CSUM 0x00 -> done=1, no writes; CSUM 0x01 -> err=1.
//  5 Frame 1 with random in_valid gaps (0-5 idle cycles) -> identical write sequence.
//  6 Assert rst after 6 payload bytes, then send frame 1 again -> exactly one write
//    per addr 0..2 after reset; reload pulse in DONE -> cpu_rst=1, ready for new frame.

Source files
------------

// File: rtl/prog_loader.sv
// Instruction-memory loader: parses a counted, checksummed byte stream, writes
// it word by word into instruction memory and holds the CPU in reset until done.
module prog_loader #(
    parameter int IM_DEPTH = 1024,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(IM_DEPTH);

    state_t              r_state;
    state_t              w_stateNext;
    logic [7:0]          r_cntHi;
    logic [15:0]         r_count;
    logic [1:0]          r_byteIdx;
    logic [23:0]         r_asm;
    logic [7:0]          r_acc;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_cpuRst;
    logic [15:0]         r_wordsLoaded;

    logic                w_ready;
    logic                w_accept;
    logic [15:0]         w_count;
    logic                w_oversize;
    logic                w_wordDone;
    logic                w_lastWord;
    logic                w_reloadOk;

    assign w_ready    = (r_state == S_CNT_HI) || (r_state == S_CNT_LO) ||
                        (r_state == S_DATA)   || (r_state == S_CSUM);
    assign w_accept   = in_valid & w_ready;
    assign w_count    = {r_cntHi, in_data};
    assign w_oversize = {1'b0, w_count} > DEPTH_L;
    // Word completion uses in_valid directly: ready is always high in DATA.
    assign w_wordDone = (r_state == S_DATA) && in_valid && (r_byteIdx == 2'd3);
    assign w_lastWord = w_wordDone && (r_wordsLoaded == (r_count - 16'd1));
    assign w_reloadOk = reload && ((r_state == S_DONE) || (r_state == S_ERR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CNT_HI;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_CNT_HI: begin
                if (in_valid) begin
                    w_stateNext = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (in_valid) begin
                    if (w_oversize) begin
                        w_stateNext = S_ERR;
                    end else if (w_count == 16'd0) begin
                        w_stateNext = S_CSUM;
                    end else begin
                        w_stateNext = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_lastWord) begin
                    w_stateNext = S_CSUM;
                end
            end
            S_CSUM: begin
                if (in_valid) begin
                    w_stateNext = (in_data == r_acc) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (reload) begin
                    w_stateNext = S_CNT_HI;
                end
            end
            default: w_stateNext = S_CNT_HI;
        endcase
    end

    // Datapath: byte assembly, checksum and the one-cycle registered memory write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cntHi       <= 8'd0;
            r_count       <= 16'd0;
            r_byteIdx     <= 2'd0;
            r_asm         <= 24'd0;
            r_acc         <= 8'd0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= 32'd0;
            r_cpuRst      <= 1'b1;
            r_wordsLoaded <= 16'd0;
        end else begin
            r_we <= 1'b0;
            if ((r_state == S_CNT_HI) && w_accept) begin
                r_cntHi <= in_data;
            end
            if ((r_state == S_CNT_LO) && w_accept) begin
                r_count   <= w_count;
                r_byteIdx <= 2'd0;
            end
            if ((r_state == S_DATA) && w_accept) begin
                r_asm     <= {r_asm[15:0], in_data};
                r_acc     <= r_acc ^ in_data;
                r_byteIdx <= r_byteIdx + 2'd1;
                if (w_wordDone) begin
                    r_wdata <= {r_asm, in_data};
                    r_addr  <= r_wordsLoaded[ADDR_W-1:0];
                    r_we    <= 1'b1;
                    if ({1'b0, r_wordsLoaded} < DEPTH_L) begin
                        r_wordsLoaded <= r_wordsLoaded + 16'd1;
                    end
                end
            end
            if (w_reloadOk) begin
                r_wordsLoaded <= 16'd0;
                r_acc         <= 8'd0;
                r_byteIdx     <= 2'd0;
            end
            r_cpuRst <= (w_stateNext != S_DONE);
        end
    end

    assign in_ready     = w_ready;
    assign im_we        = r_we;
    assign im_addr      = r_addr;
    assign im_wdata     = r_wdata;
    assign cpu_rst      = r_cpuRst;
    assign done         = (r_state == S_DONE);
    assign err          = (r_state == S_ERR);
    assign words_loaded = r_wordsLoaded;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of frame vectors, hand-written corner sequences
// and randomized frames, checked against a frame-level reference model.
module tb_prog_loader;

    localparam int IM_DEPTH = 1024;
    localparam int ADDR_W   = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              reload;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;
    logic [15:0]       words_loaded;

    prog_loader #(.IM_DEPTH(IM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .reload(reload), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .cpu_rst(cpu_rst), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] count;
        logic [7:0]  csumFlip;
        int          gapMax;
        logic        expDone;
        logic        expErr;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          readyMiss = 0;
    int          gotAddr[$];
    logic [31:0] gotData[$];
    logic [31:0] words[$];
    logic [7:0]  txBytes[$];
    vec_t        vecs[8];

    always @(negedge clk) begin
        if (!rst && im_we) begin
            gotAddr.push_back(int'(im_addr));
            gotData.push_back(im_wdata);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyReset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; reload = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        gotAddr.delete(); gotData.delete();
    endtask

    task automatic pulseReload();
        reload = 1'b1;
        @(posedge clk);
        #1 reload = 1'b0;
    endtask

    // Reference model: frame bytes and checksum derived from the word list.
    task automatic buildFrame(input logic [15:0] count, input bit randomWords, input logic [7:0] csumFlip);
        logic [7:0] c;
        c = 8'd0;
        txBytes.delete();
        if (randomWords) begin
            words.delete();
            if (int'(count) <= IM_DEPTH)
                for (int i = 0; i < int'(count); i++) words.push_back($urandom);
        end
        txBytes.push_back(count[15:8]);
        txBytes.push_back(count[7:0]);
        if (int'(count) <= IM_DEPTH) begin
            for (int i = 0; i < words.size(); i++) begin
                for (int k = 3; k >= 0; k--) begin
                    txBytes.push_back(8'((words[i] >> (8 * k)) & 32'hFF));
                    c = c ^ 8'((words[i] >> (8 * k)) & 32'hFF);
                end
            end
            txBytes.push_back(c ^ csumFlip);
        end
    endtask

    task automatic applyStimulus(input int gapMax, input int nBytes, input bit noise);
        int g;
        for (int i = 0; i < nBytes; i++) begin
            g = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
            repeat (g) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                reload   = noise && ($urandom_range(0, 3) == 0);
                @(posedge clk);
                #1;
            end
            reload   = 1'b0;
            in_valid = 1'b1;
            in_data  = txBytes[i];
            if (!in_ready) readyMiss++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        reload   = 1'b0;
    endtask

    task automatic checkFrame(input string tag, input logic expDone, input logic expErr, input int expN);
        repeat (2) @(posedge clk);
        #1;
        checkOutput({tag, ".done"}, 32'(done), 32'(expDone));
        checkOutput({tag, ".err"}, 32'(err), 32'(expErr));
        checkOutput({tag, ".cpuRst"}, 32'(cpu_rst), 32'(!expDone));
        checkOutput({tag, ".inReady"}, 32'(in_ready), 32'd0);
        checkOutput({tag, ".wordsLoaded"}, 32'(words_loaded), 32'(expN));
        checkOutput({tag, ".writeCount"}, 32'(gotData.size()), 32'(expN));
        checkOutput({tag, ".readyMiss"}, 32'(readyMiss), 32'd0);
        for (int i = 0; i < expN && i < gotData.size(); i++) begin
            checkOutput({tag, ".addr"}, 32'(gotAddr[i]), 32'(i));
            checkOutput({tag, ".data"}, gotData[i], words[i]);
        end
    endtask

    task automatic runFrame(input string tag, input logic [15:0] count, input bit randomWords,
                            input logic [7:0] csumFlip, input int gapMax, input bit noise,
                            input logic expDone, input logic expErr);
        int expN;
        buildFrame(count, randomWords, csumFlip);
        expN = (int'(count) <= IM_DEPTH) ? int'(count) : 0;
        gotAddr.delete(); gotData.delete();
        readyMiss = 0;
        applyStimulus(gapMax, txBytes.size(), noise);
        checkFrame(tag, expDone, expErr, expN);
    endtask

    task automatic setFrame1();
        words.delete();
        words.push_back(32'h20020005);
        words.push_back(32'h2003000C);
        words.push_back(32'h00000000);
    endtask

    initial begin
        logic [15:0] rc;
        logic [7:0]  rf;

        vecs[0] = '{16'd3,    8'h00, 0, 1'b1, 1'b0};
        vecs[1] = '{16'd3,    8'h5A, 0, 1'b0, 1'b1};
        vecs[2] = '{16'd1025, 8'h00, 0, 1'b0, 1'b1};
        vecs[3] = '{16'd0,    8'h00, 0, 1'b1, 1'b0};
        vecs[4] = '{16'd0,    8'h01, 0, 1'b0, 1'b1};
        vecs[5] = '{16'd1024, 8'h00, 0, 1'b1, 1'b0};
        vecs[6] = '{16'd1,    8'h00, 5, 1'b1, 1'b0};
        vecs[7] = '{16'd5,    8'h80, 3, 1'b0, 1'b1};

        applyReset();
        checkOutput("rst.inReady", 32'(in_ready), 32'd1);
        checkOutput("rst.imWe", 32'(im_we), 32'd0);
        checkOutput("rst.imAddr", 32'(im_addr), 32'd0);
        checkOutput("rst.imWdata", im_wdata, 32'd0);
        checkOutput("rst.cpuRst", 32'(cpu_rst), 32'd1);
        checkOutput("rst.done", 32'(done), 32'd0);
        checkOutput("rst.err", 32'(err), 32'd0);
        checkOutput("rst.wordsLoaded", 32'(words_loaded), 32'd0);

        setFrame1();
        runFrame("frame1", 16'd3, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0);
        applyReset();
        setFrame1();
        runFrame("frame1Bad", 16'd3, 1'b0, 8'h01, 0, 1'b0, 1'b0, 1'b1);
        applyReset();
        setFrame1();
        runFrame("frame1Gaps", 16'd3, 1'b0, 8'h00, 5, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            applyReset();
            runFrame($sformatf("vec%0d", i), vecs[i].count, 1'b1, vecs[i].csumFlip,
                     vecs[i].gapMax, 1'b0, vecs[i].expDone, vecs[i].expErr);
        end

        // Oversize count must fail on the cycle right after the CNT_LO handshake.
        applyReset();
        buildFrame(16'h0401, 1'b1, 8'h00);
        applyStimulus(0, 2, 1'b0);
        checkOutput("oversize.errNow", 32'(err), 32'd1);

        // Reset mid-load: one word written before reset, partial second word dropped.
        applyReset();
        setFrame1();
        buildFrame(16'd3, 1'b0, 8'h00);
        readyMiss = 0;
        applyStimulus(0, 8, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("midRst.imWe", 32'(im_we), 32'd0);
        checkOutput("midRst.wordsLoaded", 32'(words_loaded), 32'd0);
        checkOutput("midRst.cpuRst", 32'(cpu_rst), 32'd1);
        checkOutput("midRst.inReady", 32'(in_ready), 32'd1);
        checkOutput("midRst.preWrites", 32'(gotData.size()), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        runFrame("afterRst", 16'd3, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0);

        pulseReload();
        checkOutput("reload.cpuRst", 32'(cpu_rst), 32'd1);
        checkOutput("reload.done", 32'(done), 32'd0);
        checkOutput("reload.err", 32'(err), 32'd0);
        checkOutput("reload.wordsLoaded", 32'(words_loaded), 32'd0);
        checkOutput("reload.inReady", 32'(in_ready), 32'd1);

        for (int n = 0; n < 20; n++) begin
            rc = 16'($urandom_range(0, 6));
            rf = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            runFrame($sformatf("rand%0d", n), rc, 1'b1, rf, 5, 1'b1, rf == 8'h00, rf != 8'h00);
            pulseReload();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
